axi_rr_arbiter: RTL and testbench
=================================

# axi_rr_arbiter

Parametrised N-master round-robin arbiter for the shared AXI slave path. It grants one master at a time for a whole transaction and holds the grant until that transaction's response handshake completes (B for writes, last R beat for reads). It then rotates priority past the served master. An optional watchdog reclaims the bus from a transaction whose response never arrives. It sits between the master-side AW/AR valid lines and the interconnect mux select.

## Interface
Parameters:
- `N_MASTERS`, 4: number of requesting masters; legal range 2..16.
- `IDX_W`, `$clog2(N_MASTERS)`: width of the granted-index output; derived, never overridden.
- `TIMEOUT_CYCLES`, 0: cycles spent in WRITE/READ before forced release; 0 disables the watchdog; legal range 0..65535.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `awvalid`  in  N_MASTERS  per-master write-address valid.
- `arvalid`  in  N_MASTERS  per-master read-address valid.
- `bvalid`, `bready`  in  1 each  shared write-response handshake.
- `bresp`  in  2  write-response code; used only for error flagging.
- `rvalid`, `rready`, `rlast`  in  1 each  shared read-data handshake.
- `rresp`  in  2  read-response code; used only for error flagging.
- `gnt`  out  N_MASTERS  one-hot registered grant; all zeros when no master is granted.
- `gnt_idx`  out  IDX_W  binary index of the granted master; valid only while `|gnt`.
- `gnt_write`  out  1  1 = granted transaction is a write, 0 = read.
- `busy`  out  1  high in WRITE or READ.
- `err_pulse`  out  1  one-cycle pulse on a completing handshake whose resp is 2'b10 (SLVERR) or 2'b11 (DECERR).
- `timeout_pulse`  out  1  one-cycle pulse on a watchdog release.

## Operation
- Master i is requesting when `awvalid[i] | arvalid[i]`.
- States: IDLE, ARB, WRITE, READ.
  - Reset enters IDLE.
  - IDLE always moves to ARB on the next edge.
- ARB, no request: stay in ARB.
- ARB, at least one request: pick the first requesting master at or above `ptr`, wrapping modulo N_MASTERS.
  - Register its one-hot `gnt` and `gnt_idx`.
  - If `awvalid` is set for that master, go to WRITE with `gnt_write`=1. Otherwise go to READ with `gnt_write`=0. Write wins when both are set.
- WRITE: hold the grant; the requests of other masters are ignored.
  - On `bvalid & bready`, go to ARB, clear `gnt`, and set `ptr` to (gnt_idx+1) mod N_MASTERS.
- READ: same as WRITE, but the exit condition is `rvalid & rready & rlast`.
  - Non-last beats do not release the grant.
- Once granted, the grant is not revoked if the master drops its valid; release happens only on the response handshake or watchdog expiry.
- Watchdog:
  - The counter clears on entry to WRITE/READ and increments each cycle spent there.
  - When it reaches TIMEOUT_CYCLES (nonzero), go to ARB, clear `gnt`, advance `ptr` as on a normal completion, and pulse `timeout_pulse`.
  - If completion and expiry fall in the same cycle, completion wins and there is no timeout pulse.
- `ptr` is IDX_W wide, resets to 0, and changes only on release. Wrap-around from N_MASTERS-1 goes to 0.
- Responses seen in ARB or IDLE are ignored.

## Timing
- Reset values: `gnt`=0, `gnt_idx`=0, `gnt_write`=0, `busy`=0, `err_pulse`=0, `timeout_pulse`=0, `ptr`=0, counter=0.
- Grant latency is 1 cycle: a request sampled in ARB at edge k gives `gnt` valid after edge k.
  - The first possible grant is 2 edges after reset deassertion (IDLE, then ARB).
- Release: the completing handshake is sampled at edge k; `gnt`=0 after edge k; ARB may re-grant after edge k+1.
  - Minimum gap between grants is one cycle with `gnt`=0.
- `err_pulse` and `timeout_pulse` are registered and high for exactly the cycle after the triggering edge.
- Reset asserted mid-transaction clears everything immediately (asynchronously); the outstanding transaction is abandoned.

## Structure
- `axi_arb_pkg` holds:
  - the state enum `arb_state_e` {IDLE, ARB, WRITE, READ};
  - the resp constants `RESP_OKAY`=2'b00, `RESP_EXOKAY`=2'b01, `RESP_SLVERR`=2'b10, `RESP_DECERR`=2'b11.
- One sub-module, `rr_pick`. It is purely combinational: masked/unmasked fixed-priority search that returns a one-hot pick, its index, and an any-request flag, parametrised by N_MASTERS.
- The FSM, pointer and watchdog live in `axi_rr_arbiter`.

## Test plan
- N=4, `awvalid`=4'b1111 held, a B handshake 3 cycles after each grant: grants follow 0,1,2,3,0 with one idle cycle between grants.
- N=4, `ptr`=3 after serving master 2; only master 1 requesting: master 1 is granted (wrap-around search), and `ptr`=2 after its release.
- Master 0 has `arvalid` set, then issues 4 R beats with `rlast` on beat 4: the grant is held through beats 1-3 and cleared the cycle after beat 4.
- Master 2 has `awvalid` and `arvalid` both set: `gnt_write`=1; a B handshake with `bresp`=2'b10 gives one `err_pulse` and releases the grant.
- TIMEOUT_CYCLES=8, granted with no response: `timeout_pulse` fires and `gnt`=0 after the 8th cycle in WRITE, and `ptr` advances. A second run with the B handshake landing exactly on cycle 8 gives a normal release with no timeout pulse.
- `rst` pulled low mid-READ with the grant held: all outputs are 0 immediately; after release, the first grant arrives 2 edges later and goes to master 0.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and AXI response codes for the round-robin slave-path arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requester at or above ptr, else first requester overall.
module rr_pick #(
    parameter int N_MASTERS = 4,
    parameter int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [N_MASTERS-1:0] pick,
    output logic [IDX_W-1:0]     pick_idx,
    output logic                 any
);

    logic [N_MASTERS-1:0] mask;
    logic [N_MASTERS-1:0] masked;
    logic [N_MASTERS-1:0] search;

    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_mask
            assign mask[gi] = (IDX_W'(gi) >= ptr);
        end
    endgenerate

    // Falling back to the unmasked vector is what makes the search wrap.
    assign masked = req & mask;
    assign search = (|masked) ? masked : req;
    assign any    = |req;

    always_comb begin
        logic found;
        found    = 1'b0;
        pick     = '0;
        pick_idx = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (search[i] && !found) begin
                found    = 1'b1;
                pick[i]  = 1'b1;
                pick_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/axi_rr_arbiter.sv
// N-master round-robin arbiter holding each grant for a whole AXI transaction,
// with an optional watchdog that reclaims the bus when a response never arrives.
module axi_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int N_MASTERS      = 4,
    parameter int IDX_W          = $clog2(N_MASTERS),
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] awvalid,
    input  logic [N_MASTERS-1:0] arvalid,
    input  logic                 bvalid,
    input  logic                 bready,
    input  logic [1:0]           bresp,
    input  logic                 rvalid,
    input  logic                 rready,
    input  logic                 rlast,
    input  logic [1:0]           rresp,
    output logic [N_MASTERS-1:0] gnt,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 gnt_write,
    output logic                 busy,
    output logic                 err_pulse,
    output logic                 timeout_pulse
);

    localparam logic [15:0] WD_LAST = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

    arb_state_e           state_reg;
    logic [IDX_W-1:0]     ptr_reg;
    logic [15:0]          wd_cnt_reg;
    logic [N_MASTERS-1:0] gnt_reg;
    logic [IDX_W-1:0]     gnt_idx_reg;
    logic                 gnt_write_reg;
    logic                 busy_reg;
    logic                 err_pulse_reg;
    logic                 timeout_pulse_reg;

    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] pick;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 pick_is_write;
    logic                 done;
    logic [1:0]           done_resp;
    logic                 wd_expire;
    logic [IDX_W-1:0]     ptr_next;

    assign req = awvalid | arvalid;

    rr_pick #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req      (req),
        .ptr      (ptr_reg),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    assign pick_is_write = |(awvalid & pick);
    assign done          = ((state_reg == WRITE) && bvalid && bready)
                        || ((state_reg == READ) && rvalid && rready && rlast);
    assign done_resp     = (state_reg == WRITE) ? bresp : rresp;
    // Counter holds the number of completed cycles in WRITE/READ, so this edge ends cycle TIMEOUT_CYCLES.
    assign wd_expire     = (TIMEOUT_CYCLES != 0) && (wd_cnt_reg == WD_LAST);
    assign ptr_next      = (gnt_idx_reg == IDX_W'(N_MASTERS - 1)) ? '0 : gnt_idx_reg + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= IDLE;
            ptr_reg           <= '0;
            wd_cnt_reg        <= '0;
            gnt_reg           <= '0;
            gnt_idx_reg       <= '0;
            gnt_write_reg     <= 1'b0;
            busy_reg          <= 1'b0;
            err_pulse_reg     <= 1'b0;
            timeout_pulse_reg <= 1'b0;
        end else begin
            err_pulse_reg     <= 1'b0;
            timeout_pulse_reg <= 1'b0;
            case (state_reg)
                IDLE: state_reg <= ARB;
                ARB: begin
                    if (pick_any) begin
                        gnt_reg       <= pick;
                        gnt_idx_reg   <= pick_idx;
                        gnt_write_reg <= pick_is_write;
                        busy_reg      <= 1'b1;
                        wd_cnt_reg    <= '0;
                        state_reg     <= pick_is_write ? WRITE : READ;
                    end
                end
                WRITE, READ: begin
                    if (done || wd_expire) begin
                        state_reg         <= ARB;
                        gnt_reg           <= '0;
                        busy_reg          <= 1'b0;
                        ptr_reg           <= ptr_next;
                        wd_cnt_reg        <= '0;
                        err_pulse_reg     <= done && resp_is_err(done_resp);
                        timeout_pulse_reg <= !done;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt           = gnt_reg;
    assign gnt_idx       = gnt_idx_reg;
    assign gnt_write     = gnt_write_reg;
    assign busy          = busy_reg;
    assign err_pulse     = err_pulse_reg;
    assign timeout_pulse = timeout_pulse_reg;

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Bench for axi_rr_arbiter: directed vector table, reset corner sequence and
// randomized traffic, all checked against a transaction-level reference model.
module tb_axi_rr_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] awvalid, arvalid;
    logic         bvalid, bready, rvalid, rready, rlast;
    logic [1:0]   bresp, rresp;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_idx;
    logic         gnt_write, busy, err_pulse, timeout_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    axi_rr_arbiter #(
        .N_MASTERS      (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .awvalid       (awvalid),
        .arvalid       (arvalid),
        .bvalid        (bvalid),
        .bready        (bready),
        .bresp         (bresp),
        .rvalid        (rvalid),
        .rready        (rready),
        .rlast         (rlast),
        .rresp         (rresp),
        .gnt           (gnt),
        .gnt_idx       (gnt_idx),
        .gnt_write     (gnt_write),
        .busy          (busy),
        .err_pulse     (err_pulse),
        .timeout_pulse (timeout_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a transaction either owns the bus or it does not;
    // the winner is the first requester scanning upward from ptr modulo N.
    bit m_started, m_busy, m_write, m_err, m_to, m_new_grant;
    int m_idx, m_cycles, m_ptr;

    function automatic void model_reset();
        m_started = 0; m_busy = 0; m_write = 0; m_err = 0; m_to = 0;
        m_idx = 0; m_cycles = 0; m_ptr = 0; m_new_grant = 0;
    endfunction

    function automatic void model_release();
        m_busy = 0;
        m_ptr  = (m_idx + 1) % N;
    endfunction

    function automatic void model_update();
        logic [N-1:0] req;
        bit finished;
        m_err = 0; m_to = 0; m_new_grant = 0;
        req = awvalid | arvalid;
        if (!m_started) begin
            m_started = 1;
        end else if (!m_busy) begin
            for (int i = 0; i < N; i++) begin
                int j;
                j = (m_ptr + i) % N;
                if (!m_busy && req[j]) begin
                    m_busy = 1; m_idx = j; m_write = awvalid[j]; m_cycles = 0; m_new_grant = 1;
                end
            end
        end else begin
            m_cycles++;
            finished = m_write ? (bvalid && bready) : (rvalid && rready && rlast);
            if (finished) begin
                m_err = m_write ? (bresp >= 2) : (rresp >= 2);
                model_release();
            end else if (TO != 0 && m_cycles == TO) begin
                m_to = 1;
                model_release();
            end
        end
    endfunction

    task automatic model_check(input string tag);
        logic [N-1:0] e_gnt;
        e_gnt = m_busy ? (N'(1) << m_idx) : '0;
        chk({tag, " gnt"}, 32'(gnt), 32'(e_gnt));
        chk({tag, " busy"}, 32'(busy), 32'(m_busy));
        chk({tag, " err_pulse"}, 32'(err_pulse), 32'(m_err));
        chk({tag, " timeout_pulse"}, 32'(timeout_pulse), 32'(m_to));
        if (m_busy) begin
            chk({tag, " gnt_idx"}, 32'(gnt_idx), 32'(m_idx));
            chk({tag, " gnt_write"}, 32'(gnt_write), 32'(m_write));
        end
        if (m_new_grant)
            $display("[TB] %s: grant master %0d %s, ptr %0d", tag, m_idx, m_write ? "write" : "read", m_ptr);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        model_check(tag);
    endtask

    typedef struct {
        logic [N-1:0] aw, ar;
        logic         bhs;
        logic [1:0]   bresp;
        logic         rhs, rlast;
        logic [1:0]   rresp;
        logic [N-1:0] eg;
        logic         ew, ee, et;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [N-1:0] aw, input logic [N-1:0] ar,
                                input logic bhs, input logic [1:0] br,
                                input logic rhs, input logic rl, input logic [1:0] rr,
                                input logic [N-1:0] eg, input logic ew,
                                input logic ee, input logic et);
        vec_t v;
        v.aw = aw; v.ar = ar; v.bhs = bhs; v.bresp = br;
        v.rhs = rhs; v.rlast = rl; v.rresp = rr;
        v.eg = eg; v.ew = ew; v.ee = ee; v.et = et;
        vecs.push_back(v);
    endfunction

    function automatic int oh2idx(input logic [N-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic clear_inputs();
        awvalid = '0; arvalid = '0;
        bvalid = 0; bready = 0; bresp = 2'b00;
        rvalid = 0; rready = 0; rlast = 0; rresp = 2'b00;
    endtask

    initial begin
        int master_order[5];
        master_order = '{0, 1, 2, 3, 0};
        rst = 1'b0;
        clear_inputs();
        model_reset();

        // IDLE -> ARB edge, then four-way contention with B three cycles after each grant.
        add(4'hF, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        for (int g = 0; g < 5; g++) begin
            logic [N-1:0] oh;
            oh = N'(1) << master_order[g];
            add(4'hF, 0, 0, 0, 0, 0, 0, oh, 1, 0, 0);
            add(4'hF, 0, 0, 0, 0, 0, 0, oh, 1, 0, 0);
            add(4'hF, 0, 0, 0, 0, 0, 0, oh, 1, 0, 0);
            add(4'hF, 0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        end
        // Serve master 2 (ptr -> 3), then lone master 1 read wraps around; ptr -> 2 shown by next pick.
        add(4'h4, 0, 0, 0, 0, 0, 0, 4'h4, 1, 0, 0);
        add(4'h0, 0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        add(4'h0, 4'h2, 0, 0, 0, 0, 0, 4'h2, 0, 0, 0);
        add(4'h0, 4'h2, 0, 0, 1, 1, 0, 4'h0, 0, 0, 0);
        add(4'hF, 0, 0, 0, 0, 0, 0, 4'h4, 1, 0, 0);
        add(4'h0, 0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        // Four-beat read by master 0; DECERR on the last beat flags an error.
        add(4'h0, 4'h1, 0, 0, 0, 0, 0, 4'h1, 0, 0, 0);
        for (int b = 0; b < 3; b++) add(4'h0, 0, 0, 0, 1, 0, 0, 4'h1, 0, 0, 0);
        add(4'h0, 0, 0, 0, 1, 1, 2'b11, 4'h0, 0, 1, 0);
        // Master 2 with both valids: write wins, SLVERR releases with one err pulse.
        add(4'h4, 4'h4, 0, 0, 0, 0, 0, 4'h4, 1, 0, 0);
        add(4'h0, 0, 1, 2'b10, 0, 0, 0, 4'h0, 0, 1, 0);
        add(4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        // Responses while in ARB are ignored.
        add(4'h0, 0, 1, 2'b11, 1, 1, 2'b11, 4'h0, 0, 0, 0);
        // Watchdog expiry after the 8th cycle in WRITE.
        add(4'h1, 0, 0, 0, 0, 0, 0, 4'h1, 1, 0, 0);
        for (int c = 0; c < 7; c++) add(4'h0, 0, 0, 0, 0, 0, 0, 4'h1, 1, 0, 0);
        add(4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1);
        add(4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        // B handshake on exactly the 8th cycle: completion wins, no timeout.
        add(4'h2, 0, 0, 0, 0, 0, 0, 4'h2, 1, 0, 0);
        for (int c = 0; c < 7; c++) add(4'h0, 0, 0, 0, 0, 0, 0, 4'h2, 1, 0, 0);
        add(4'h0, 0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        add(4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset gnt", 32'(gnt), 0);
        chk("reset gnt_idx", 32'(gnt_idx), 0);
        chk("reset gnt_write", 32'(gnt_write), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset err_pulse", 32'(err_pulse), 0);
        chk("reset timeout_pulse", 32'(timeout_pulse), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            vec_t v;
            string tag;
            v = vecs[k];
            tag = $sformatf("vec%0d", k);
            awvalid = v.aw; arvalid = v.ar;
            bvalid = v.bhs; bready = v.bhs; bresp = v.bresp;
            rvalid = v.rhs; rready = v.rhs; rlast = v.rlast; rresp = v.rresp;
            step(tag);
            chk({tag, " tbl gnt"}, 32'(gnt), 32'(v.eg));
            chk({tag, " tbl busy"}, 32'(busy), 32'(|v.eg));
            chk({tag, " tbl err_pulse"}, 32'(err_pulse), 32'(v.ee));
            chk({tag, " tbl timeout_pulse"}, 32'(timeout_pulse), 32'(v.et));
            if (v.eg != 0) begin
                chk({tag, " tbl gnt_idx"}, 32'(gnt_idx), 32'(oh2idx(v.eg)));
                chk({tag, " tbl gnt_write"}, 32'(gnt_write), 32'(v.ew));
            end
        end

        // Reset mid-READ: master 3 reading (ptr was 2), one non-last beat, then async reset.
        clear_inputs();
        arvalid = 4'h8;
        step("rstseq grant");
        chk("rstseq gnt", 32'(gnt), 32'h8);
        arvalid = 4'h0;
        rvalid = 1; rready = 1; rlast = 0;
        step("rstseq beat");
        chk("rstseq held", 32'(gnt), 32'h8);
        clear_inputs();
        awvalid = 4'hF;
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async rst gnt", 32'(gnt), 0);
        chk("async rst busy", 32'(busy), 0);
        chk("async rst gnt_idx", 32'(gnt_idx), 0);
        chk("async rst err", 32'(err_pulse | timeout_pulse | gnt_write), 0);
        @(negedge clk);
        rst = 1'b1;
        step("post-rst idle");
        chk("post-rst edge1 gnt", 32'(gnt), 0);
        step("post-rst grant");
        chk("post-rst edge2 gnt", 32'(gnt), 32'h1);
        awvalid = '0;
        bvalid = 1; bready = 1;
        step("post-rst release");
        clear_inputs();

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            awvalid = N'($urandom) & N'($urandom);
            arvalid = N'($urandom) & N'($urandom);
            bvalid  = ($urandom_range(0, 3) == 0);
            bready  = $urandom_range(0, 1) == 1;
            bresp   = 2'($urandom);
            rvalid  = ($urandom_range(0, 2) == 0);
            rready  = $urandom_range(0, 1) == 1;
            rlast   = ($urandom_range(0, 2) == 0);
            rresp   = 2'($urandom);
            step($sformatf("rnd%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
